// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes,
// FSM state encoding and default memory map.
package mem_pkg;

    // Default memory map: first mapped byte and size of the backing memory.
    localparam logic [31:0] BASE_ADDR_DEF = 32'h0100_0000;
    localparam int unsigned MEM_BYTES_DEF = 1000000;

    // RV32I funct3 width codes for loads and stores.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // IDLE accepts requests; RMW_WR is the write half of a sub-word store.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_t;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half from a loaded word and sign- or
// zero-extends it according to the RV32I width code.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by width-dependent extension.
    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        result = word;
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_BU:   result = {24'h0, byte_sel};
            F3_HU:   result = {16'h0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between execute and a single-ported word memory.
// Loads and word stores complete in one cycle; byte/half stores use a
// two-cycle read-modify-write. Faulting requests never touch memory.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; upstream holds the request while req_ready is
// low. resp_valid is a single-cycle pulse with no backpressure.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_read_write,
    output logic        state_dbg
);

    state_t      state;
    state_t      state_next;

    logic        accept;
    logic        fault;
    logic        misaligned;
    logic        bad_code;
    logic        out_of_range;
    logic        store_word;
    logic        store_rmw;
    logic [32:0] addr_ext;
    logic [32:0] end_addr;
    logic [31:0] aligned_addr;
    logic [31:0] merged;
    logic [31:0] load_result;
    logic [31:0] rmw_addr;
    logic [31:0] rmw_data;

    assign accept       = req_valid & req_ready;
    assign aligned_addr = {req_addr[31:2], 2'b00};
    assign addr_ext     = {1'b0, req_addr};
    // 33-bit end address so addresses near 4 GiB cannot wrap the range test.
    assign end_addr     = {1'b0, BASE_ADDR} + 33'(MEM_BYTES);

    // Fault classification of the presented request.
    always_comb begin
        misaligned   = 1'b0;
        bad_code     = 1'b0;
        out_of_range = 1'b0;
        if ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0])
            misaligned = 1'b1;
        if (req_funct3 == F3_W && req_addr[1:0] != 2'b00)
            misaligned = 1'b1;
        if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
            bad_code = 1'b1;
        if (req_is_store && (req_funct3 == F3_BU || req_funct3 == F3_HU))
            bad_code = 1'b1;
        if (req_addr < BASE_ADDR || (addr_ext + 33'd3) >= end_addr)
            out_of_range = 1'b1;
        fault = misaligned | bad_code | out_of_range;
    end

    assign store_word = accept & req_is_store & ~fault & (req_funct3 == F3_W);
    assign store_rmw  = accept & req_is_store & ~fault & (req_funct3 != F3_W);

    // Merge the low byte/half of the store data into the word just read.
    always_comb begin
        merged = mem_rdata;
        if (req_funct3 == F3_B) begin
            case (req_addr[1:0])
                2'd0: merged[7:0]   = req_wdata[7:0];
                2'd1: merged[15:8]  = req_wdata[7:0];
                2'd2: merged[23:16] = req_wdata[7:0];
                2'd3: merged[31:24] = req_wdata[7:0];
                default: merged = mem_rdata;
            endcase
        end else if (req_addr[1]) begin
            merged[31:16] = req_wdata[15:0];
        end else begin
            merged[15:0] = req_wdata[15:0];
        end
    end

    load_extend u_load_extend (
        .word    (mem_rdata),
        .addr_lo (req_addr[1:0]),
        .funct3  (req_funct3),
        .result  (load_result)
    );

    // State register; reset abandons any pending RMW write.
    always_ff @(posedge clock) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic: only a good sub-word store leaves IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (store_rmw) state_next = ST_RMW_WR;
            ST_RMW_WR: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output logic: handshake and memory port drive per state.
    always_comb begin
        req_ready      = 1'b0;
        mem_address    = aligned_addr;
        mem_wdata      = req_wdata;
        mem_read_write = 1'b1;
        case (state)
            ST_IDLE: begin
                req_ready      = ~reset;
                mem_address    = store_word ? req_addr : aligned_addr;
                mem_wdata      = req_wdata;
                mem_read_write = ~store_word;
            end
            ST_RMW_WR: begin
                req_ready      = 1'b0;
                mem_address    = rmw_addr;
                mem_wdata      = rmw_data;
                mem_read_write = reset;
            end
            default: begin
                req_ready      = 1'b0;
                mem_read_write = 1'b1;
            end
        endcase
    end

    assign state_dbg = state;

    // Capture the merged word and its aligned address for the write cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rmw_addr <= 32'h0;
            rmw_data <= 32'h0;
        end else if (store_rmw) begin
            rmw_addr <= aligned_addr;
            rmw_data <= merged;
        end
    end

    // Response pulse: one cycle after acceptance, or after the RMW write.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_data  <= 32'h0;
            resp_rd    <= 5'd0;
        end else begin
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_data  <= 32'h0;
            resp_rd    <= 5'd0;
            if (state == ST_RMW_WR) begin
                resp_valid <= 1'b1;
            end else if (accept) begin
                if (fault) begin
                    resp_valid <= 1'b1;
                    resp_fault <= 1'b1;
                end else if (!req_is_store) begin
                    resp_valid <= 1'b1;
                    resp_data  <= load_result;
                    resp_rd    <= req_rd;
                end else if (req_funct3 == F3_W) begin
                    resp_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory covering
// 0x0100_0000..0x0100_00FF (reads outside it return zero).
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_read_write;
    logic        state_dbg;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_words [0:63] = '{default: 32'h0};
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_data = 32'h0;
    logic        in_win;
    logic [5:0]  widx;

    mem_access_unit dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_store   (req_is_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_rd         (req_rd),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_rd        (resp_rd),
        .resp_fault     (resp_fault),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_read_write (mem_read_write),
        .state_dbg      (state_dbg)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory block: combinational read, word write on the rising edge.
    assign in_win    = (mem_address[31:8] == 24'h010000);
    assign widx      = mem_address[7:2];
    assign mem_rdata = in_win ? mem_words[widx] : 32'h0;

    always @(posedge clock) begin
        if (pre_we)
            mem_words[pre_idx] <= pre_data;
        else if (!mem_read_write && in_win)
            mem_words[widx] <= mem_wdata;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = a;
        req_wdata    = wd;
        req_rd       = rd;
    endtask

    task automatic idle();
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = 3'b000;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_rd       = 5'd0;
    endtask

    task automatic chk_resp(input string tag, input logic v, input logic f,
                            input logic [31:0] d, input logic [4:0] rd);
        chk({tag, "_valid"}, {31'h0, resp_valid}, {31'h0, v});
        chk({tag, "_fault"}, {31'h0, resp_fault}, {31'h0, f});
        chk({tag, "_data"}, resp_data, d);
        chk({tag, "_rd"}, {27'h0, resp_rd}, {27'h0, rd});
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        idle();

        // Preload memory while reset is held.
        pre_we = 1'b1; pre_idx = 6'd4;  pre_data = 32'h8070_F0A5;
        tick();
        pre_idx = 6'd12; pre_data = 32'hCAFE_BABE;
        tick();
        pre_we = 1'b0;

        // A store presented during reset must be ignored.
        req(1'b1, F3_W, 32'h0100_0040, 32'h5555_AAAA, 5'd0);
        settle();
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_mem_rw", {31'h0, mem_read_write}, 32'h1);
        tick();
        chk_resp("rst", 1'b0, 1'b0, 32'h0, 5'd0);
        chk("rst_state", {31'h0, state_dbg}, 32'h0);
        idle();
        reset = 1'b0;

        // Loads from word 0x8070_F0A5, back to back.
        req(1'b0, F3_B, 32'h0100_0010, 32'h0, 5'd5);
        settle();
        chk("lb_ready", {31'h0, req_ready}, 32'h1);
        chk("lb_addr", mem_address, 32'h0100_0010);
        chk("lb_rw", {31'h0, mem_read_write}, 32'h1);
        tick();
        chk_resp("lb", 1'b1, 1'b0, 32'hFFFF_FFA5, 5'd5);
        req(1'b0, F3_BU, 32'h0100_0011, 32'h0, 5'd6);
        tick();
        chk_resp("lbu", 1'b1, 1'b0, 32'h0000_00F0, 5'd6);
        req(1'b0, F3_H, 32'h0100_0012, 32'h0, 5'd7);
        tick();
        chk_resp("lh", 1'b1, 1'b0, 32'hFFFF_8070, 5'd7);
        req(1'b0, F3_HU, 32'h0100_0012, 32'h0, 5'd8);
        tick();
        chk_resp("lhu", 1'b1, 1'b0, 32'h0000_8070, 5'd8);
        req(1'b0, F3_W, 32'h0100_0010, 32'h0, 5'd9);
        tick();
        chk_resp("lw", 1'b1, 1'b0, 32'h8070_F0A5, 5'd9);
        req(1'b0, F3_B, 32'h0100_0013, 32'h0, 5'd10);
        tick();
        chk_resp("lb3", 1'b1, 1'b0, 32'hFFFF_FF80, 5'd10);
        idle();
        tick();
        chk("idle_valid", {31'h0, resp_valid}, 32'h0);

        // SB 0x12345678 to byte 1 of 0x8070_F0A5.
        req(1'b1, F3_B, 32'h0100_0011, 32'h1234_5678, 5'd31);
        settle();
        chk("sb_acc_ready", {31'h0, req_ready}, 32'h1);
        chk("sb_acc_rw", {31'h0, mem_read_write}, 32'h1);
        chk("sb_acc_addr", mem_address, 32'h0100_0010);
        tick();
        idle();
        settle();
        chk("sb_wr_state", {31'h0, state_dbg}, 32'h1);
        chk("sb_wr_ready", {31'h0, req_ready}, 32'h0);
        chk("sb_wr_rw", {31'h0, mem_read_write}, 32'h0);
        chk("sb_wr_addr", mem_address, 32'h0100_0010);
        chk("sb_wr_data", mem_wdata, 32'h8070_78A5);
        chk("sb_wr_valid", {31'h0, resp_valid}, 32'h0);
        tick();
        chk_resp("sb", 1'b1, 1'b0, 32'h0, 5'd0);
        chk("sb_state", {31'h0, state_dbg}, 32'h0);
        chk("sb_ready", {31'h0, req_ready}, 32'h1);
        chk("sb_mem", mem_words[4], 32'h8070_78A5);

        // Faulting requests.
        req(1'b0, F3_W, 32'h0100_0002, 32'h0, 5'd3);
        settle();
        chk("lw_mis_rw", {31'h0, mem_read_write}, 32'h1);
        tick();
        chk_resp("lw_mis", 1'b1, 1'b1, 32'h0, 5'd0);
        req(1'b1, F3_W, 32'h0000_0000, 32'hFFFF_FFFF, 5'd4);
        settle();
        chk("sw_low_rw", {31'h0, mem_read_write}, 32'h1);
        tick();
        chk_resp("sw_low", 1'b1, 1'b1, 32'h0, 5'd0);
        req(1'b0, 3'b011, 32'h0100_0010, 32'h0, 5'd5);
        tick();
        chk_resp("f3_011", 1'b1, 1'b1, 32'h0, 5'd0);
        req(1'b1, F3_BU, 32'h0100_0010, 32'h0000_00EE, 5'd6);
        settle();
        chk("sbu_rw", {31'h0, mem_read_write}, 32'h1);
        tick();
        chk_resp("sbu", 1'b1, 1'b1, 32'h0, 5'd0);
        req(1'b0, F3_W, 32'h010F_423C, 32'h0, 5'd6);
        tick();
        chk_resp("lw_top_ok", 1'b1, 1'b0, 32'h0, 5'd6);
        req(1'b0, F3_W, 32'h010F_4240, 32'h0, 5'd7);
        tick();
        chk_resp("lw_top_bad", 1'b1, 1'b1, 32'h0, 5'd0);
        req(1'b0, F3_B, 32'h00FF_FFFF, 32'h0, 5'd8);
        tick();
        chk_resp("lb_below", 1'b1, 1'b1, 32'h0, 5'd0);
        req(1'b0, F3_H, 32'h0100_0011, 32'h0, 5'd9);
        tick();
        chk_resp("lh_mis", 1'b1, 1'b1, 32'h0, 5'd0);
        idle();
        tick();
        chk("flt_idle_valid", {31'h0, resp_valid}, 32'h0);
        chk("flt_mem4", mem_words[4], 32'h8070_78A5);
        chk("rst_store_ignored", mem_words[16], 32'h0);

        // SW then LW at the same address on consecutive cycles.
        req(1'b1, F3_W, 32'h0100_0020, 32'hDEAD_BEEF, 5'd10);
        settle();
        chk("sw_rw", {31'h0, mem_read_write}, 32'h0);
        chk("sw_addr", mem_address, 32'h0100_0020);
        chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        req(1'b0, F3_W, 32'h0100_0020, 32'h0, 5'd11);
        chk_resp("sw", 1'b1, 1'b0, 32'h0, 5'd0);
        settle();
        chk("lw_after_sw_ready", {31'h0, req_ready}, 32'h1);
        tick();
        chk_resp("lw_after_sw", 1'b1, 1'b0, 32'hDEAD_BEEF, 5'd11);
        idle();

        // SH upper half over 0xCAFE_BABE.
        req(1'b1, F3_H, 32'h0100_0032, 32'h1111_BEEF, 5'd1);
        tick();
        idle();
        settle();
        chk("sh_wr_addr", mem_address, 32'h0100_0030);
        chk("sh_wr_data", mem_wdata, 32'hBEEF_BABE);
        chk("sh_wr_rw", {31'h0, mem_read_write}, 32'h0);
        tick();
        chk_resp("sh", 1'b1, 1'b0, 32'h0, 5'd0);
        chk("sh_mem", mem_words[12], 32'hBEEF_BABE);

        // Reset during the RMW write cycle abandons the write.
        req(1'b1, F3_H, 32'h0100_0030, 32'h0000_1234, 5'd2);
        tick();
        idle();
        settle();
        chk("abort_state_wr", {31'h0, state_dbg}, 32'h1);
        chk("abort_pending_data", mem_wdata, 32'hBEEF_1234);
        reset = 1'b1;
        settle();
        chk("abort_rst_rw", {31'h0, mem_read_write}, 32'h1);
        chk("abort_rst_ready", {31'h0, req_ready}, 32'h0);
        tick();
        chk("abort_state", {31'h0, state_dbg}, 32'h0);
        chk("abort_valid", {31'h0, resp_valid}, 32'h0);
        chk("abort_rw_hold", {31'h0, mem_read_write}, 32'h1);
        chk("abort_mem", mem_words[12], 32'hBEEF_BABE);
        reset = 1'b0;
        tick();
        chk("abort_valid_after", {31'h0, resp_valid}, 32'h0);
        chk("abort_mem_after", mem_words[12], 32'hBEEF_BABE);
        chk("abort_state_after", {31'h0, state_dbg}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0100_0000, meaning the byte address mapped to memory byte 0.
REQ-002 The block SHALL have parameter MEM_BYTES, default 1000000, meaning the memory size in bytes.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  upstream (execute) request present.
REQ-006 req_ready  out  1  request accepted this cycle when req_valid & req_ready.
REQ-007 req_is_store  in  1  1 = store, 0 = load.
REQ-008 req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  in  32  byte address; req_wdata  in  32  store data; req_rd  in  5  load destination register.
REQ-010 resp_valid  out  1  one-cycle completion pulse to writeback; no backpressure.
REQ-011 resp_data  out  32  extended load data; resp_rd  out  5  destination register; resp_fault  out  1  access faulted.
REQ-012 mem_address  out  32; mem_wdata  out  32; mem_rdata  in  32; mem_read_write  out  1. These connect to the memory block: 1 = combinational read, 0 = 4-byte write at the clock edge.

Function
REQ-013 The FSM SHALL have two states. IDLE SHALL drive req_ready=1. RMW_WR SHALL drive req_ready=0.
REQ-014 mem_read_write SHALL be 1 in every cycle except the single write cycle of an accepted store.
REQ-015 A fault SHALL be detected when:
- H/HU with addr[0]=1;
- W with addr[1:0]!=0;
- funct3 is 011, 110 or 111, or BU/HU with req_is_store=1;
- addr < BASE_ADDR;
- addr+3 >= BASE_ADDR+MEM_BYTES.
REQ-016 On an accepted faulting request: no memory write occurs; the next cycle gives resp_valid=1, resp_fault=1, resp_data=0, resp_rd=0.
REQ-017 On an accepted load in IDLE: the block drives mem_address = {addr[31:2],2'b00} with read_write=1, and registers the extracted lane. The next cycle gives resp_valid=1, resp_rd=req_rd, latency 1, and state stays IDLE (one load per cycle).
REQ-018 Load extraction SHALL work as follows:
- B/H select lane addr[1:0] or addr[1].
- B/H sign-extend; BU/HU zero-extend.
- W passes through.
REQ-019 An accepted W store SHALL drive mem_address=addr, mem_wdata=req_wdata and read_write=0 in the accept cycle. The next cycle gives resp_valid=1, resp_rd=0, resp_data=0. State stays IDLE.
REQ-020 An accepted B/H store SHALL use read-modify-write:
- Accept cycle: read the aligned word, merge the low byte or half of req_wdata into lane addr[1:0], and latch the merged word and aligned address; go to RMW_WR.
- RMW_WR cycle: write the merged word with read_write=0, then return to IDLE.
- resp_valid follows in the next cycle (total latency 2, throughput 1 per 2 cycles).
REQ-021 resp_valid SHALL be low in every cycle not named in REQ-016/017/019/020. resp_rd SHALL be 0 for stores and faults.
REQ-022 req_valid while req_ready=0 SHALL be ignored; upstream holds the request.

Reset
REQ-023 While reset=1 at a clock edge, the FSM SHALL go to IDLE, resp_valid/resp_fault to 0, resp_data to 0, and resp_rd to 0.
REQ-024 While reset=1, mem_read_write SHALL be 1 and no request is accepted.
REQ-025 Reset asserted in RMW_WR SHALL abandon the pending write; memory keeps its old value.

Structure
REQ-026 Package mem_pkg SHALL hold the funct3 encodings, the state enum, and the BASE_ADDR/MEM_BYTES defaults.
REQ-027 Sub-module load_extend SHALL hold the combinational lane select and extension (word, addr[1:0], funct3 -> 32-bit result). Lane merge SHALL stay inline.

Verification
REQ-028 Preload word 32'h8070_F0A5 at 0x0100_0010. LB at 0x0100_0010 -> resp_data 32'hFFFF_FFA5 one cycle later. LBU at 0x0100_0011 -> 32'h0000_00F0. LH at 0x0100_0012 -> 32'hFFFF_8070.
REQ-029 SB of 32'h1234_5678 to 0x0100_0011 over word 32'h8070_F0A5:
- req_ready low for 1 cycle;
- memory word becomes 32'h8070_78A5;
- resp_valid 2 cycles after accept.
REQ-030 Faults:
- LW at 0x0100_0002 -> resp_fault=1, no write;
- SW at 0x0000_0000 -> resp_fault=1, memory unchanged;
- funct3 011 -> resp_fault=1.
REQ-031 Back-to-back SW 0xDEAD_BEEF at 0x0100_0020 then LW from the same address -> 2 resp_valid pulses on consecutive cycles; load returns 32'hDEAD_BEEF.
REQ-032 Assert reset in the RMW_WR cycle of SH to 0x0100_0030 -> no write occurs, FSM in IDLE, resp_valid stays 0, mem_read_write=1 throughout reset.
